// File: rtl/bcd_field_editor_if.sv
// bcd_field_editor_if
//   Groups the set-up path signals of the BCD field editor.
//   master : drives EN, load_data and the four debounced button levels,
//            observes data_out, cursor, editing, changed.
//   slave  : the editor itself (mirror image of master).
interface bcd_field_editor_if #(
  parameter int NFIELDS = 3
);
  localparam int CW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  logic                   EN;
  logic [8*NFIELDS-1:0]   load_data;
  logic                   BTup;
  logic                   BTdown;
  logic                   BTl;
  logic                   BTr;
  logic [8*NFIELDS-1:0]   data_out;
  logic [CW-1:0]          cursor;
  logic                   editing;
  logic                   changed;

  modport master (
    output EN, load_data, BTup, BTdown, BTl, BTr,
    input  data_out, cursor, editing, changed
  );

  modport slave (
    input  EN, load_data, BTup, BTdown, BTl, BTr,
    output data_out, cursor, editing, changed
  );
endinterface

// File: rtl/bcd_field_editor.sv
// bcd_field_editor
//   Edits a packed value of NFIELDS two-digit BCD fields in place. On EN the
//   value is captured (invalid or over-range fields forced to 00), then
//   left/right buttons move a field cursor and up/down step the selected
//   field in BCD, with per-field maximum, wrap/saturate and auto-repeat.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     bus (slave)       : EN, load_data, BTup/BTdown/BTl/BTr in;
//                         data_out, cursor, editing, changed out (all registered)
module bcd_field_editor #(
  parameter int                   NFIELDS      = 3,
  parameter logic [8*NFIELDS-1:0] FIELD_MAX    = {8'h23, 8'h59, 8'h59},
  parameter bit                   WRAP         = 1'b1,
  parameter logic [15:0]          REPEAT_DELAY = 16'd25000,
  parameter logic [15:0]          REPEAT_RATE  = 16'd5000
) (
  input  logic              clk,
  input  logic              reset,
  bcd_field_editor_if.slave bus
);
  localparam int W  = 8 * NFIELDS;
  localparam int CW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_EDIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          editing_q, editing_d;
  logic          changed_q, changed_d;
  logic          pend_q, pend_d;      // a button modified data_out this edge
  logic [3:0]    btn_prev_q, btn_prev_d;
  logic [15:0]   rep_q, rep_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
    if (v == mx)               return WRAP ? 8'h00 : v;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'h0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
    if (v == 8'h00)            return WRAP ? mx : v;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'h9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Ordering of valid BCD codes matches their binary ordering, so a plain
  // compare against the maximum is enough once both nibbles are known valid.
  function automatic logic [7:0] sanitise(input logic [7:0] v, input logic [7:0] mx);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > mx) return 8'h00;
    else                                          return v;
  endfunction

  // Button order in the edge registers: {up, down, left, right}
  logic [3:0] btn, rise;
  assign btn  = {bus.BTup, bus.BTdown, bus.BTl, bus.BTr};
  assign rise = btn & ~btn_prev_q;

  // Both up and down held (or both rising) is treated as no request at all.
  logic one_held, press, rep_fire;
  logic [16:0] rep_inc;
  assign one_held = bus.BTup ^ bus.BTdown;
  assign press    = one_held && (rise[3] || rise[2]);
  assign rep_inc  = {1'b0, rep_q} + 17'd1;
  // After the first repeat the counter is parked at REPEAT_DELAY, so every
  // later repeat is the moment it climbs REPEAT_RATE above that.
  assign rep_fire = !press && ((rep_inc == {1'b0, REPEAT_DELAY}) ||
                    (rep_inc == ({1'b0, REPEAT_DELAY} + {1'b0, REPEAT_RATE})));

  logic [7:0] fld_cur  [NFIELDS];
  logic [7:0] fld_step [NFIELDS];
  logic [7:0] fld_load [NFIELDS];

  // Field gi sits at bits [W-1-8*gi -: 8]; field 0 is most significant.
  for (genvar gi = 0; gi < NFIELDS; gi++) begin : g_field
    assign fld_cur[gi]  = data_q[W-1-8*gi -: 8];
    assign fld_step[gi] = bus.BTup ? bcd_inc(fld_cur[gi], FIELD_MAX[W-1-8*gi -: 8])
                                   : bcd_dec(fld_cur[gi], FIELD_MAX[W-1-8*gi -: 8]);
    assign fld_load[gi] = sanitise(bus.load_data[W-1-8*gi -: 8], FIELD_MAX[W-1-8*gi -: 8]);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cursor_d   = cursor_q;
    rep_d      = '0;
    pend_d     = 1'b0;
    changed_d  = pend_q;
    btn_prev_d = btn;
    case (state_q)
      S_IDLE: begin
        cursor_d = '0;
        if (bus.EN) state_d = S_LOAD;
      end
      S_LOAD: begin
        cursor_d = '0;
        if (bus.EN) begin
          state_d = S_EDIT;
          for (int i = 0; i < NFIELDS; i++) data_d[W-1-8*i -: 8] = fld_load[i];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EDIT: begin
        if (!bus.EN) begin
          state_d  = S_IDLE;
          cursor_d = '0;
        end else begin
          if (rise[1] && !rise[0])
            cursor_d = (cursor_q == '0) ? CW'(NFIELDS - 1) : cursor_q - CW'(1);
          else if (rise[0] && !rise[1])
            cursor_d = (cursor_q == CW'(NFIELDS - 1)) ? '0 : cursor_q + CW'(1);
          if (one_held && !press)
            rep_d = rep_fire ? REPEAT_DELAY : rep_inc[15:0];
          // Step uses the pre-move cursor.
          if (one_held && (press || rep_fire)) begin
            for (int i = 0; i < NFIELDS; i++) begin
              if (cursor_q == CW'(i)) begin
                data_d[W-1-8*i -: 8] = fld_step[i];
                if (fld_step[i] != fld_cur[i]) pend_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    editing_d = (state_d == S_EDIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      cursor_q   <= '0;
      editing_q  <= 1'b0;
      changed_q  <= 1'b0;
      pend_q     <= 1'b0;
      btn_prev_q <= '0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cursor_q   <= cursor_d;
      editing_q  <= editing_d;
      changed_q  <= changed_d;
      pend_q     <= pend_d;
      btn_prev_q <= btn_prev_d;
      rep_q      <= rep_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.cursor   = cursor_q;
  assign bus.editing  = editing_q;
  assign bus.changed  = changed_q;
endmodule

// File: tb/tb_bcd_field_editor.sv
// tb_bcd_field_editor
//   Two editors share one stimulus stream: dut_a wraps, dut_b saturates,
//   both with a short auto-repeat (delay 8, rate 4). Stimulus pushes
//   expected snapshots and expected changed-pulse values into queues; the
//   monitors compare on the falling edge whenever the DUT presents them.
module tb_bcd_field_editor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        en_tb  = 1'b0;
  logic [23:0] ld_tb  = '0;
  logic [3:0]  btn_tb = '0;   // {up, down, left, right}

  localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_L = 4'b0010, B_R = 4'b0001;

  bcd_field_editor_if #(.NFIELDS(3)) ifa ();
  bcd_field_editor_if #(.NFIELDS(3)) ifb ();

  assign ifa.EN = en_tb;  assign ifa.load_data = ld_tb;
  assign ifa.BTup = btn_tb[3]; assign ifa.BTdown = btn_tb[2];
  assign ifa.BTl = btn_tb[1];  assign ifa.BTr = btn_tb[0];
  assign ifb.EN = en_tb;  assign ifb.load_data = ld_tb;
  assign ifb.BTup = btn_tb[3]; assign ifb.BTdown = btn_tb[2];
  assign ifb.BTl = btn_tb[1];  assign ifb.BTr = btn_tb[0];

  bcd_field_editor #(.NFIELDS(3), .FIELD_MAX({8'h23, 8'h59, 8'h59}), .WRAP(1'b1),
                     .REPEAT_DELAY(16'd8), .REPEAT_RATE(16'd4))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bcd_field_editor #(.NFIELDS(3), .FIELD_MAX({8'h23, 8'h59, 8'h59}), .WRAP(1'b0),
                     .REPEAT_DELAY(16'd8), .REPEAT_RATE(16'd4))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  cur;
    logic        ed;
    logic        chg;
  } snap_t;

  snap_t       snap_qa[$], snap_qb[$];
  string       name_qa[$], name_qb[$];
  logic [23:0] chg_qa[$], chg_qb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp2(input string nm, input logic [23:0] da, input logic [23:0] db,
                      input logic [1:0] c, input logic e, input logic ca, input logic cb);
    snap_qa.push_back('{data: da, cur: c, ed: e, chg: ca}); name_qa.push_back(nm);
    snap_qb.push_back('{data: db, cur: c, ed: e, chg: cb}); name_qb.push_back(nm);
  endtask

  task automatic press(input logic [3:0] m, input string nm);
    btn_tb = m;
    cyc(1);
    btn_tb = '0;
    cyc(1);
    $display("txn %s", nm);
  endtask

  task automatic restart(input logic [23:0] v);
    en_tb = 1'b0;
    cyc(1);
    ld_tb = v;
    en_tb = 1'b1;
    cyc(2);
    $display("txn load %h", v);
  endtask

  // Monitor A
  always @(negedge clk) begin
    snap_t s;
    string n;
    while (snap_qa.size() > 0) begin
      s = snap_qa.pop_front();
      n = name_qa.pop_front();
      check({n, " A data"},    32'(ifa.data_out), 32'(s.data));
      check({n, " A cursor"},  32'(ifa.cursor),   32'(s.cur));
      check({n, " A editing"}, 32'(ifa.editing),  32'(s.ed));
      check({n, " A changed"}, 32'(ifa.changed),  32'(s.chg));
    end
    if (ifa.changed) begin
      if (chg_qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL A changed pulse: got 1 expected 0 (data_out %h)", ifa.data_out);
      end else begin
        check("A data at changed", 32'(ifa.data_out), 32'(chg_qa.pop_front()));
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    snap_t s;
    string n;
    while (snap_qb.size() > 0) begin
      s = snap_qb.pop_front();
      n = name_qb.pop_front();
      check({n, " B data"},    32'(ifb.data_out), 32'(s.data));
      check({n, " B cursor"},  32'(ifb.cursor),   32'(s.cur));
      check({n, " B editing"}, 32'(ifb.editing),  32'(s.ed));
      check({n, " B changed"}, 32'(ifb.changed),  32'(s.chg));
    end
    if (ifb.changed) begin
      if (chg_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL B changed pulse: got 1 expected 0 (data_out %h)", ifb.data_out);
      end else begin
        check("B data at changed", 32'(ifb.data_out), 32'(chg_qb.pop_front()));
      end
    end
  end

  initial begin
    cyc(2);
    exp2("reset", 24'h0, 24'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1);

    // Load: LOAD state first, then EDIT with the captured value.
    ld_tb = 24'h125930;
    en_tb = 1'b1;
    cyc(1);
    exp2("load state", 24'h0, 24'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    exp2("load 125930", 24'h125930, 24'h125930, 2'd0, 1'b1, 1'b0, 1'b0);

    press(B_R, "right");
    exp2("right1", 24'h125930, 24'h125930, 2'd1, 1'b1, 1'b0, 1'b0);
    press(B_R, "right");
    exp2("right2", 24'h125930, 24'h125930, 2'd2, 1'b1, 1'b0, 1'b0);
    chg_qa.push_back(24'h125931); chg_qb.push_back(24'h125931);
    press(B_UP, "up 30");
    exp2("up 30", 24'h125931, 24'h125931, 2'd2, 1'b1, 1'b1, 1'b1);

    en_tb = 1'b0;
    cyc(2);
    exp2("idle hold", 24'h125931, 24'h125931, 2'd0, 1'b0, 1'b0, 1'b0);

    // Sanitising: 24 > 23 and nibble A both give 00.
    ld_tb = 24'h246A10;
    en_tb = 1'b1;
    cyc(2);
    exp2("load 246A10", 24'h000010, 24'h000010, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_L, "left");
    exp2("left1", 24'h000010, 24'h000010, 2'd2, 1'b1, 1'b0, 1'b0);
    press(B_L, "left");
    exp2("left2", 24'h000010, 24'h000010, 2'd1, 1'b1, 1'b0, 1'b0);
    press(B_L, "left");
    exp2("left3", 24'h000010, 24'h000010, 2'd0, 1'b1, 1'b0, 1'b0);

    // Max boundary: 59 wraps in A, saturates in B.
    restart(24'h005959);
    exp2("load 005959", 24'h005959, 24'h005959, 2'd0, 1'b1, 1'b0, 1'b0);
    press(B_L, "left");
    chg_qa.push_back(24'h005900);
    press(B_UP, "up at max");
    exp2("up at max", 24'h005900, 24'h005959, 2'd2, 1'b1, 1'b1, 1'b0);

    // Zero boundary on hours: 00 -> 23 in A, holds in B.
    press(B_R, "right wrap");
    chg_qa.push_back(24'h235900);
    press(B_DN, "down at zero");
    exp2("down at zero", 24'h235900, 24'h005959, 2'd0, 1'b1, 1'b1, 1'b0);
    press(B_UP | B_DN, "up+down");
    exp2("up+down", 24'h235900, 24'h005959, 2'd0, 1'b1, 1'b0, 1'b0);

    // Auto-repeat: held over edges m..m+20 -> steps at m, m+8, m+12, m+16, m+20.
    restart(24'h000005);
    press(B_L, "left");
    chg_qa.push_back(24'h000006); chg_qb.push_back(24'h000006);
    chg_qa.push_back(24'h000007); chg_qb.push_back(24'h000007);
    chg_qa.push_back(24'h000008); chg_qb.push_back(24'h000008);
    chg_qa.push_back(24'h000009); chg_qb.push_back(24'h000009);
    chg_qa.push_back(24'h000010); chg_qb.push_back(24'h000010);
    btn_tb = B_UP;
    cyc(21);
    btn_tb = '0;
    cyc(2);
    $display("txn hold up 21 edges");
    exp2("repeat", 24'h000010, 24'h000010, 2'd2, 1'b1, 1'b0, 1'b0);

    // Button already held when EN rises: no step.
    en_tb = 1'b0;
    btn_tb = B_UP;
    cyc(1);
    ld_tb = 24'h000005;
    en_tb = 1'b1;
    cyc(3);
    $display("txn load with up held");
    exp2("held at EN", 24'h000005, 24'h000005, 2'd0, 1'b1, 1'b0, 1'b0);
    btn_tb = '0;
    cyc(1);

    // Reset in the middle of a repeat.
    chg_qa.push_back(24'h010005); chg_qb.push_back(24'h010005);
    chg_qa.push_back(24'h020005); chg_qb.push_back(24'h020005);
    btn_tb = B_UP;
    cyc(10);
    reset = 1'b1;
    cyc(1);
    $display("txn reset during repeat");
    exp2("mid reset", 24'h0, 24'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    reset = 1'b0;
    btn_tb = '0;
    en_tb = 1'b0;
    cyc(3);

    check("A pending changed", 32'(chg_qa.size()), 32'd0);
    check("B pending changed", 32'(chg_qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
